// File: rtl/hazard_scoreboard_if.sv
//==============================================================================
// Module      : hazard_scoreboard_if
// Description : ID-stage hazard bus between the IF/ID latch, the EX operand
//               muxes and the hazard scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
    parameter int RW      = 5,
    parameter int NSTAGES = 3,
    parameter int CNT_W   = 16
);
    localparam int c_SEL_W = $clog2(NSTAGES);

    logic               ifid_valid;
    logic [RW-1:0]      ifid_rs;
    logic [RW-1:0]      ifid_rt;
    logic               ifid_rt_used;
    logic [RW-1:0]      ifid_rd;
    logic               ifid_RegWEN;
    logic               ifid_MemRead;
    logic               flush;
    logic               dmem_wait;
    logic               stall;
    logic               pc_en;
    logic               idex_bubble;
    logic [c_SEL_W-1:0] fwd_rs_sel;
    logic [c_SEL_W-1:0] fwd_rt_sel;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   fwd_cnt;

    modport master (
        output ifid_valid, ifid_rs, ifid_rt, ifid_rt_used, ifid_rd,
               ifid_RegWEN, ifid_MemRead, flush, dmem_wait,
        input  stall, pc_en, idex_bubble, fwd_rs_sel, fwd_rt_sel,
               stall_cnt, fwd_cnt
    );

    modport slave (
        input  ifid_valid, ifid_rs, ifid_rt, ifid_rt_used, ifid_rd,
               ifid_RegWEN, ifid_MemRead, flush, dmem_wait,
        output stall, pc_en, idex_bubble, fwd_rs_sel, fwd_rt_sel,
               stall_cnt, fwd_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
//==============================================================================
// Module      : hazard_scoreboard
// Description : Shift-register scoreboard of in-flight writers producing
//               load-use stalls, registered forwarding selects and counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int RW         = 5,
    parameter int NSTAGES    = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input  wire logic          CLK,
    input  wire logic          nRST,
    hazard_scoreboard_if.slave bus
);
    localparam int c_SEL_W = $clog2(NSTAGES);
    localparam int c_PW    = $clog2(NSTAGES + 1);
    localparam int c_CW1   = CNT_W + 1;
    localparam logic [c_PW-1:0] c_LR_POS  = c_PW'(LOAD_READY);
    localparam logic [c_PW-1:0] c_END_POS = c_PW'(NSTAGES);

    logic [NSTAGES-1:0] v_q, v_d;
    logic [NSTAGES-1:0] ld_q, ld_d;
    logic [RW-1:0]      rd_q [NSTAGES];
    logic [RW-1:0]      rd_d [NSTAGES];
    logic [c_SEL_W-1:0] fwd_rs_sel_q, fwd_rs_sel_d;
    logic [c_SEL_W-1:0] fwd_rt_sel_q, fwd_rt_sel_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;

    logic               w_rs_hit, w_rt_hit;
    logic               w_rs_ld, w_rt_ld;
    logic [c_PW-1:0]    w_rs_pos, w_rt_pos;
    logic               w_rs_rdy, w_rt_rdy;
    logic               w_stall;
    logic               w_adv;
    logic [c_SEL_W-1:0] w_rs_sel, w_rt_sel;
    logic [1:0]         w_fwd_inc;
    logic [CNT_W:0]     w_fwd_sum;

    // Scan oldest to youngest so the youngest matching writer is the one kept.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rs_ld  = 1'b0;
        w_rs_pos = '0;
        w_rt_hit = 1'b0;
        w_rt_ld  = 1'b0;
        w_rt_pos = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (v_q[k] && (bus.ifid_rs != '0) && (rd_q[k] == bus.ifid_rs)) begin
                w_rs_hit = 1'b1;
                w_rs_ld  = ld_q[k];
                w_rs_pos = c_PW'(k + 1);
            end
            if (v_q[k] && bus.ifid_rt_used && (bus.ifid_rt != '0) &&
                (rd_q[k] == bus.ifid_rt)) begin
                w_rt_hit = 1'b1;
                w_rt_ld  = ld_q[k];
                w_rt_pos = c_PW'(k + 1);
            end
        end
    end

    assign w_rs_rdy = !w_rs_ld || (w_rs_pos >= c_LR_POS);
    assign w_rt_rdy = !w_rt_ld || (w_rt_pos >= c_LR_POS);

    assign w_stall = bus.ifid_valid && !bus.flush &&
                     ((w_rs_hit && !w_rs_rdy) || (w_rt_hit && !w_rt_rdy));

    assign w_adv = !bus.dmem_wait;

    // A producer sitting in the last entry retires into the write-first regfile.
    assign w_rs_sel = (w_rs_hit && w_rs_rdy && (w_rs_pos < c_END_POS) &&
                       !w_stall && !bus.flush) ? c_SEL_W'(w_rs_pos) : '0;
    assign w_rt_sel = (w_rt_hit && w_rt_rdy && (w_rt_pos < c_END_POS) &&
                       !w_stall && !bus.flush) ? c_SEL_W'(w_rt_pos) : '0;

    assign w_fwd_inc = {1'b0, (w_rs_sel != '0)} + {1'b0, (w_rt_sel != '0)};
    assign w_fwd_sum = {1'b0, fwd_cnt_q} + c_CW1'(w_fwd_inc);

    always_comb begin
        v_d          = v_q;
        ld_d         = ld_q;
        rd_d         = rd_q;
        fwd_rs_sel_d = fwd_rs_sel_q;
        fwd_rt_sel_d = fwd_rt_sel_q;
        stall_cnt_d  = stall_cnt_q;
        fwd_cnt_d    = fwd_cnt_q;
        if (w_adv) begin
            for (int k = 1; k < NSTAGES; k++) begin
                v_d[k]  = v_q[k-1];
                ld_d[k] = ld_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
            v_d[0]  = bus.ifid_valid && bus.ifid_RegWEN && (bus.ifid_rd != '0) &&
                      !w_stall && !bus.flush;
            ld_d[0] = bus.ifid_MemRead;
            rd_d[0] = bus.ifid_rd;
            fwd_rs_sel_d = w_rs_sel;
            fwd_rt_sel_d = w_rt_sel;
            if (w_stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            fwd_cnt_d = w_fwd_sum[CNT_W] ? '1 : w_fwd_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v_q  <= '0;
            ld_q <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                rd_q[k] <= '0;
            end
            fwd_rs_sel_q <= '0;
            fwd_rt_sel_q <= '0;
            stall_cnt_q  <= '0;
            fwd_cnt_q    <= '0;
        end else begin
            v_q          <= v_d;
            ld_q         <= ld_d;
            rd_q         <= rd_d;
            fwd_rs_sel_q <= fwd_rs_sel_d;
            fwd_rt_sel_q <= fwd_rt_sel_d;
            stall_cnt_q  <= stall_cnt_d;
            fwd_cnt_q    <= fwd_cnt_d;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.pc_en       = !w_stall && !bus.dmem_wait;
    assign bus.idex_bubble = (w_stall || bus.flush) && !bus.dmem_wait;
    assign bus.fwd_rs_sel  = fwd_rs_sel_q;
    assign bus.fwd_rt_sel  = fwd_rt_sel_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.fwd_cnt     = fwd_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
//==============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed bench for hazard_scoreboard, default and 4-stage builds.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_scoreboard;
    logic CLK = 1'b0;
    logic nRST;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard_if #(.RW(5), .NSTAGES(3), .CNT_W(16)) a_if ();
    hazard_scoreboard_if #(.RW(5), .NSTAGES(4), .CNT_W(16)) b_if ();

    hazard_scoreboard #(.RW(5), .NSTAGES(3), .LOAD_READY(2), .CNT_W(16)) u_dut_a (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (a_if.slave)
    );

    hazard_scoreboard #(.RW(5), .NSTAGES(4), .LOAD_READY(3), .CNT_W(16)) u_dut_b (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rtu, input logic [4:0] rd, input logic wen,
                         input logic ld);
        a_if.ifid_valid   = v;
        a_if.ifid_rs      = rs;
        a_if.ifid_rt      = rt;
        a_if.ifid_rt_used = rtu;
        a_if.ifid_rd      = rd;
        a_if.ifid_RegWEN  = wen;
        a_if.ifid_MemRead = ld;
        #1;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rtu, input logic [4:0] rd, input logic wen,
                         input logic ld);
        b_if.ifid_valid   = v;
        b_if.ifid_rs      = rs;
        b_if.ifid_rt      = rt;
        b_if.ifid_rt_used = rtu;
        b_if.ifid_rd      = rd;
        b_if.ifid_RegWEN  = wen;
        b_if.ifid_MemRead = ld;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        a_if.flush = 1'b0;
        a_if.dmem_wait = 1'b0;
        b_if.flush = 1'b0;
        b_if.dmem_wait = 1'b0;
        set_a(0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_rs_sel", a_if.fwd_rs_sel, 0);
        chk("rst_rt_sel", a_if.fwd_rt_sel, 0);
        chk("rst_stall_cnt", a_if.stall_cnt, 0);
        chk("rst_fwd_cnt", a_if.fwd_cnt, 0);
        chk("rst_stall", a_if.stall, 0);
        nRST = 1'b1;

        // ALU back-to-back: add $8 ; sub $9,$8,$8
        tick();
        set_a(1, 1, 2, 1, 8, 1, 0);
        chk("alu_p_stall", a_if.stall, 0);
        tick();
        set_a(1, 8, 8, 1, 9, 1, 0);
        chk("alu_c_stall", a_if.stall, 0);
        chk("alu_c_pc_en", a_if.pc_en, 1);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 0);
        chk("alu_rs_sel", a_if.fwd_rs_sel, 1);
        chk("alu_rt_sel", a_if.fwd_rt_sel, 1);
        chk("alu_fwd_cnt", a_if.fwd_cnt, 2);
        tick(); tick(); tick();

        // Load-use: lw $8 ; add $9,$8,$0
        set_a(1, 29, 0, 0, 8, 1, 1);
        tick();
        set_a(1, 8, 0, 1, 9, 1, 0);
        chk("lu_stall", a_if.stall, 1);
        chk("lu_bubble", a_if.idex_bubble, 1);
        chk("lu_pc_en", a_if.pc_en, 0);
        tick();
        chk("lu_stall2", a_if.stall, 0);
        chk("lu_stall_cnt", a_if.stall_cnt, 1);
        chk("lu_bubble_sel", a_if.fwd_rs_sel, 0);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 0);
        chk("lu_rs_sel", a_if.fwd_rs_sel, 2);
        chk("lu_rt_sel", a_if.fwd_rt_sel, 0);
        chk("lu_fwd_cnt", a_if.fwd_cnt, 3);
        tick(); tick(); tick();

        // Youngest wins, then retirement
        set_a(1, 1, 2, 1, 8, 1, 0);
        tick();
        set_a(1, 3, 4, 1, 8, 1, 0);
        tick();
        set_a(1, 8, 0, 1, 10, 1, 0);
        chk("yw_stall", a_if.stall, 0);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 0);
        chk("yw_rs_sel", a_if.fwd_rs_sel, 1);
        chk("yw_fwd_cnt", a_if.fwd_cnt, 4);
        tick();
        tick();
        set_a(1, 10, 0, 1, 13, 1, 0);
        chk("ret_stall", a_if.stall, 0);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 0);
        chk("ret_rs_sel", a_if.fwd_rs_sel, 0);
        chk("ret_fwd_cnt", a_if.fwd_cnt, 4);
        tick(); tick(); tick();

        // Freeze during load-use
        set_a(1, 29, 0, 0, 8, 1, 1);
        tick();
        a_if.dmem_wait = 1'b1;
        set_a(1, 8, 0, 1, 9, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("frz_stall", a_if.stall, 1);
            chk("frz_pc_en", a_if.pc_en, 0);
            chk("frz_bubble", a_if.idex_bubble, 0);
            chk("frz_stall_cnt", a_if.stall_cnt, 1);
            tick();
        end
        a_if.dmem_wait = 1'b0;
        #1;
        chk("frz_rel_stall", a_if.stall, 1);
        chk("frz_rel_bubble", a_if.idex_bubble, 1);
        tick();
        chk("frz_stall2", a_if.stall, 0);
        chk("frz_stall_cnt2", a_if.stall_cnt, 2);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 0);
        chk("frz_rs_sel", a_if.fwd_rs_sel, 2);
        chk("frz_fwd_cnt", a_if.fwd_cnt, 5);
        tick(); tick(); tick();

        // Flush with a pending hazard
        set_a(1, 29, 0, 0, 8, 1, 1);
        tick();
        a_if.flush = 1'b1;
        set_a(1, 8, 0, 1, 9, 1, 0);
        chk("fl_stall", a_if.stall, 0);
        chk("fl_bubble", a_if.idex_bubble, 1);
        tick();
        a_if.flush = 1'b0;
        set_a(1, 9, 0, 1, 10, 1, 0);
        chk("fl_sel", a_if.fwd_rs_sel, 0);
        chk("fl_next_stall", a_if.stall, 0);
        tick();
        chk("fl_no_insert_sel", a_if.fwd_rs_sel, 0);
        chk("fl_stall_cnt", a_if.stall_cnt, 2);

        // rt not used never matches
        set_a(1, 29, 0, 0, 8, 1, 1);
        tick();
        set_a(1, 0, 8, 0, 9, 1, 0);
        chk("rtu0_stall", a_if.stall, 0);
        tick();
        set_a(1, 9, 0, 1, 12, 1, 0);
        chk("rtu0_rt_sel", a_if.fwd_rt_sel, 0);
        tick();
        set_a(1, 12, 12, 1, 13, 1, 0);
        chk("pre_rst_rs_sel", a_if.fwd_rs_sel, 1);
        chk("pre_rst_fwd_cnt", a_if.fwd_cnt, 6);

        // Asynchronous reset mid-stream
        nRST = 1'b0;
        #1;
        chk("arst_rs_sel", a_if.fwd_rs_sel, 0);
        chk("arst_stall_cnt", a_if.stall_cnt, 0);
        chk("arst_fwd_cnt", a_if.fwd_cnt, 0);
        chk("arst_stall", a_if.stall, 0);
        tick();
        nRST = 1'b1;
        #1;
        chk("post_rst_stall", a_if.stall, 0);
        tick();
        set_a(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_rs_sel", a_if.fwd_rs_sel, 0);
        chk("post_rst_rt_sel", a_if.fwd_rt_sel, 0);
        chk("post_rst_fwd_cnt", a_if.fwd_cnt, 0);

        // Four-stage build, load ready at entry 3
        set_b(1, 29, 0, 0, 8, 1, 1);
        tick();
        set_b(1, 8, 0, 1, 9, 1, 0);
        chk("b_stall1", b_if.stall, 1);
        tick();
        chk("b_stall2", b_if.stall, 1);
        tick();
        chk("b_stall3", b_if.stall, 0);
        chk("b_stall_cnt", b_if.stall_cnt, 2);
        tick();
        set_b(1, 29, 0, 0, 10, 1, 1);
        chk("b_rs_sel", b_if.fwd_rs_sel, 3);
        chk("b_fwd_cnt", b_if.fwd_cnt, 1);
        tick();
        set_b(1, 0, 10, 0, 11, 1, 0);
        chk("b_rtu0_stall", b_if.stall, 0);
        set_b(1, 0, 10, 1, 11, 1, 0);
        chk("b_rtu1_stall", b_if.stall, 1);
        set_b(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit.
- Tracks in-flight register writers across a configurable number of post-decode stages with a shift-register scoreboard.
- Generates load-use stalls for any load latency, registered forwarding selects for the EX operands, flush/freeze gating, and stall/forward event counters.
- Sits between the IF/ID latch and the EX operand muxes of the MIPS pipeline.

Parameters:
- RW, 5, register index width.
- NSTAGES, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB, ...); min 2.
- LOAD_READY, 2, entry position at which load data is forwardable (1 ≤ LOAD_READY < NSTAGES).
- CNT_W, 16, width of event counters.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- ifid_valid  in  1  ID holds a real instruction.
- ifid_rs  in  RW  source 1.
- ifid_rt  in  RW  source 2.
- ifid_rt_used  in  1  rt is a source (R-type/store/branch).
- ifid_rd  in  RW  resolved destination.
- ifid_RegWEN  in  1  instruction writes rd.
- ifid_MemRead  in  1  instruction is a load.
- flush  in  1  branch/jump resolved taken; kill ID instruction.
- dmem_wait  in  1  data memory busy; freeze whole pipe.
- stall  out  1  load-use hazard (combinational).
- pc_en  out  1  PC/IF-ID enable = !stall && !dmem_wait.
- idex_bubble  out  1  insert nop into ID/EX = (stall || flush) && !dmem_wait.
- fwd_rs_sel  out  clog2(NSTAGES)  EX rs source: 0 = regfile, p = entry p.
- fwd_rt_sel  out  clog2(NSTAGES)  same for rt.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- fwd_cnt  out  CNT_W  saturating count of non-zero forward selects issued.

Behaviour:
- Scoreboard: NSTAGES entries {v, rd, ld}.
- Reset (async, nRST=0): all entries v=0; fwd_rs_sel, fwd_rt_sel, stall_cnt, fwd_cnt = 0. Reset mid-operation discards all tracking at once.
- Advance when !dmem_wait:
  - entry[k+1] <= entry[k].
  - entry[NSTAGES-1] retires (regfile write-first, visible to the next ID read).
  - entry[0] <= {ifid_valid && ifid_RegWEN && ifid_rd!=0 && !stall && !flush, ifid_rd, ifid_MemRead}; otherwise a bubble (v=0).
- dmem_wait=1: scoreboard, selects and counters hold. stall still evaluates combinationally, but pc_en=0 and idex_bubble=0.
- Match per source s (rs; rt only if ifid_rt_used; s!=0): youngest (lowest k) valid entry with rd==s. Only the youngest match counts.
- Next position of the match p = k+1. Ready iff !ld ? p ≥ 1 : p ≥ LOAD_READY.
- stall = ifid_valid && !flush && (any matched source not ready). Flush has priority: stall=0 when flush=1.
- Forward selects, registered on advance:
  - next sel = p if matched and ready and p < NSTAGES; else 0.
  - Select is 0 on a stall or flush cycle (bubble enters EX).
- Stall duration for a back-to-back load-use is LOAD_READY-1 cycles. Each stall cycle re-evaluates; the bubble shifts the load forward one position.
- stall_cnt += 1 per cycle with stall && !dmem_wait.
- fwd_cnt += (rs sel≠0) + (rt sel≠0) per advance.
- Both counters saturate at all-ones.
- $zero is never tracked nor matched.

Test Plan (defaults):
- Reset: assert nRST=0 mid-stream with entries valid → all outputs 0 immediately; after release, a dependent add sees sel=0 and stall=0.
- ALU back-to-back: add $8 then sub $9,$8,$8 → no stall; fwd_rs_sel=fwd_rt_sel=1 in the sub's EX cycle; fwd_cnt=2.
- Load-use: lw $8 then add $9,$8,$0 → stall=1 for exactly 1 cycle, idex_bubble=1; then fwd_rs_sel=2, fwd_rt_sel=0; stall_cnt=1.
- Youngest wins and retirement: add $8; add $8; add $10,$8 → sel=1 (youngest). Producer 3 slots ahead → sel=0 (retired).
- Freeze/flush: dmem_wait=1 for 4 cycles during load-use → stall stays 1, pc_en=0, stall_cnt unchanged. flush=1 with a pending hazard → stall=0, idex_bubble=1, no entry inserted.
- Param sweep: NSTAGES=4, LOAD_READY=3 → back-to-back load-use gives 2 stall cycles, then sel=3. rt with ifid_rt_used=0 never stalls.
